// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared constants, state type and address helper for the AXI4-Lite demo macro
package axi4lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] REG_A   = 2'd0;
  localparam logic [1:0] REG_B   = 2'd1;
  localparam logic [1:0] REG_SUM = 2'd2;
  localparam logic [1:0] REG_ID  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_READ,
    ST_RDATA,
    ST_FINISH
  } mst_state_e;

  // Word-aligned byte address of a register index.
  function automatic logic [AXI_ADDR_W-1:0] reg_addr(input logic [1:0] idx);
    return {28'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/axi4lite_if.sv
// rtl/axi4lite_if.sv - AXI4-Lite bus bundle with master and slave views
interface axi4lite_if;
  import axi4lite_pkg::*;

  logic [AXI_ADDR_W-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [AXI_DATA_W-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4lite_regs.sv
// rtl/axi4lite_regs.sv - AXI4-Lite slave: two R/W bytes, a wrapping sum and a constant ID
module axi4lite_regs
  import axi4lite_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  axi4lite_if.slave  bus
);

  logic [7:0] reg_a_q, reg_b_q;
  logic       wr_rdy_q, bvalid_q;
  logic [1:0] bresp_q;
  logic       arready_q, rvalid_q;
  logic [7:0] rdata_q;
  logic [7:0] rd_byte;
  logic [1:0] wr_idx, rd_idx;
  logic       wr_hs, ar_hs, wr_ok;
  logic       unused_bits;

  assign wr_idx = bus.awaddr[3:2];
  assign rd_idx = bus.araddr[3:2];
  assign wr_hs  = wr_rdy_q & bus.awvalid & bus.wvalid;
  assign ar_hs  = arready_q & bus.arvalid;
  assign wr_ok  = (wr_idx == REG_A) || (wr_idx == REG_B);

  always_comb begin
    rd_byte = 8'h00;
    case (rd_idx)
      REG_A:   rd_byte = reg_a_q;
      REG_B:   rd_byte = reg_b_q;
      REG_SUM: rd_byte = reg_a_q + reg_b_q;
      default: rd_byte = ID_VALUE;
    endcase
  end

  // Ready strobes are single-cycle pulses; a pending response blocks new ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a_q   <= 8'h00;
      reg_b_q   <= 8'h00;
      wr_rdy_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      wr_rdy_q <= !wr_rdy_q && bus.awvalid && bus.wvalid && !bvalid_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (bus.wstrb[0] && wr_idx == REG_A) reg_a_q <= bus.wdata[7:0];
        if (bus.wstrb[0] && wr_idx == REG_B) reg_b_q <= bus.wdata[7:0];
      end else if (bvalid_q && bus.bready) begin
        bvalid_q <= 1'b0;
      end

      arready_q <= !arready_q && bus.arvalid && !rvalid_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_byte;
      end else if (rvalid_q && bus.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign bus.awready = wr_rdy_q;
  assign bus.wready  = wr_rdy_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = {24'b0, rdata_q};
  assign bus.rresp   = RESP_OKAY;

  assign unused_bits = ^{bus.awaddr[31:4], bus.awaddr[1:0], bus.awprot, bus.wstrb[3:1],
                         bus.wdata[31:8], bus.araddr[31:4], bus.araddr[1:0], bus.arprot};

endmodule

// File: rtl/tt_um_axi4lite_top.sv
// rtl/tt_um_axi4lite_top.sv - pin-driven AXI4-Lite master talking to the internal register slave
module tt_um_axi4lite_top
  import axi4lite_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  axi4lite_if bus ();

  axi4lite_regs #(.ID_VALUE(ID_VALUE)) u_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mst_state_e state_q, state_d;
  logic       start_q;
  logic [1:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0] resp_q, resp_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d, done_q, done_d, error_q, error_d, lww_q, lww_d;
  logic [3:0] stat_q;
  logic       launch;
  logic       unused_pins;

  assign launch = (state_q == ST_IDLE) && !start_q && uio_in[3];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    lww_d     = lww_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          idx_d     = uio_in[1:0];
          data_d    = ui_in;
          lww_d     = uio_in[2];
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = uio_in[2] ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (bus.awvalid && bus.awready) aw_done_d = 1'b1;
        if (bus.wvalid && bus.wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)      state_d   = ST_WRESP;
      end
      ST_WRESP: begin
        if (bus.bvalid) begin
          resp_d  = bus.bresp;
          state_d = ST_FINISH;
        end
      end
      ST_READ: begin
        if (bus.arready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (bus.rvalid) begin
          rdata_d = bus.rdata[7:0];
          resp_d  = bus.rresp;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        error_d = (resp_q != RESP_OKAY);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status pins go through one extra register so done lands on the fifth edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      idx_q     <= 2'b00;
      data_q    <= 8'h00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      lww_q     <= 1'b0;
      stat_q    <= 4'b0000;
    end else begin
      state_q   <= state_d;
      start_q   <= uio_in[3];
      idx_q     <= idx_d;
      data_q    <= data_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      lww_q     <= lww_d;
      stat_q    <= {lww_q, error_q, done_q, busy_q};
    end
  end

  // Valids depend only on registered state, never on the incoming readies.
  assign bus.awvalid = (state_q == ST_WRITE) && !aw_done_q;
  assign bus.wvalid  = (state_q == ST_WRITE) && !w_done_q;
  assign bus.awaddr  = reg_addr(idx_q);
  assign bus.awprot  = 3'b000;
  assign bus.wdata   = {24'b0, data_q};
  assign bus.wstrb   = 4'b0001;
  assign bus.bready  = (state_q == ST_WRESP);
  assign bus.arvalid = (state_q == ST_READ);
  assign bus.araddr  = reg_addr(idx_q);
  assign bus.arprot  = 3'b000;
  assign bus.rready  = (state_q == ST_RDATA);

  assign uo_out  = rdata_q;
  assign uio_out = {stat_q, 4'b0000};
  assign uio_oe  = 8'hF0;

  assign unused_pins = ^{ena, uio_in[7:4], bus.rdata[31:8]};

endmodule

// File: tb/tb_tt_um_axi4lite_top.sv
// tb/tb_tt_um_axi4lite_top.sv - directed self-checking bench for tt_um_axi4lite_top
module tb_tt_um_axi4lite_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tt_um_axi4lite_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Passive copy of the internal bus for handshake-rule checks.
  axi4lite_if mon ();
  assign mon.awaddr  = dut.bus.awaddr;
  assign mon.awprot  = dut.bus.awprot;
  assign mon.awvalid = dut.bus.awvalid;
  assign mon.awready = dut.bus.awready;
  assign mon.wdata   = dut.bus.wdata;
  assign mon.wstrb   = dut.bus.wstrb;
  assign mon.wvalid  = dut.bus.wvalid;
  assign mon.wready  = dut.bus.wready;
  assign mon.bresp   = dut.bus.bresp;
  assign mon.bvalid  = dut.bus.bvalid;
  assign mon.bready  = dut.bus.bready;
  assign mon.araddr  = dut.bus.araddr;
  assign mon.arprot  = dut.bus.arprot;
  assign mon.arvalid = dut.bus.arvalid;
  assign mon.arready = dut.bus.arready;
  assign mon.rdata   = dut.bus.rdata;
  assign mon.rresp   = dut.bus.rresp;
  assign mon.rvalid  = dut.bus.rvalid;
  assign mon.rready  = dut.bus.rready;

  logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  logic [31:0] aw_addr_prev = '0, ar_addr_prev = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    end else begin
      if (aw_pend) begin
        check("awvalid_hold", mon.awvalid, 1);
        check("awaddr_stable", mon.awaddr, aw_addr_prev);
      end
      if (w_pend)  check("wvalid_hold", mon.wvalid, 1);
      if (ar_pend) begin
        check("arvalid_hold", mon.arvalid, 1);
        check("araddr_stable", mon.araddr, ar_addr_prev);
      end
      if (b_pend)  check("bvalid_hold", mon.bvalid, 1);
      if (r_pend)  check("rvalid_hold", mon.rvalid, 1);
      aw_pend = mon.awvalid & ~mon.awready;
      w_pend  = mon.wvalid  & ~mon.wready;
      ar_pend = mon.arvalid & ~mon.arready;
      b_pend  = mon.bvalid  & ~mon.bready;
      r_pend  = mon.rvalid  & ~mon.rready;
      aw_addr_prev = mon.awaddr;
      ar_addr_prev = mon.araddr;
    end
  end

  // One transaction with its latency checked: busy still up at edge 4, done at edge 5.
  task automatic txn(input logic [1:0] idx, input logic rw, input logic [7:0] data, input string tag);
    @(negedge clk);
    ui_in  = data;
    uio_in = {4'b0000, 1'b1, rw, idx};
    @(negedge clk);
    uio_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_edge4"}, {30'b0, uio_out[5:4]}, 32'h1);
    @(negedge clk);
    check({tag, "_edge5"}, {30'b0, uio_out[5:4]}, 32'h2);
  endtask

  int busy_cyc;
  int rises;
  logic prev_busy;

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_uio_out", uio_out, 8'h00);
    check("idle_uo_out", uo_out, 8'h00);

    txn(2'd3, 1'b0, 8'h00, "rd_id");
    check("rd_id_data", uo_out, 8'hA5);
    check("rd_id_status", uio_out, 8'h20);

    txn(2'd0, 1'b1, 8'h3C, "wr_a");
    check("wr_a_status", uio_out, 8'hA0);
    check("wr_a_uo_kept", uo_out, 8'hA5);
    txn(2'd0, 1'b0, 8'h00, "rd_a");
    check("rd_a_data", uo_out, 8'h3C);
    check("rd_a_status", uio_out, 8'h20);

    txn(2'd0, 1'b1, 8'hF0, "wr_a2");
    txn(2'd1, 1'b1, 8'h20, "wr_b");
    txn(2'd2, 1'b0, 8'h00, "rd_sum");
    check("rd_sum_wrap", uo_out, 8'h10);
    txn(2'd1, 1'b0, 8'h00, "rd_b");
    check("rd_b_data", uo_out, 8'h20);

    txn(2'd3, 1'b1, 8'h55, "wr_id");
    check("wr_id_status", uio_out, 8'hE0);
    check("wr_id_uo_kept", uo_out, 8'h20);
    txn(2'd3, 1'b0, 8'h00, "rd_id2");
    check("rd_id2_data", uo_out, 8'hA5);
    check("rd_id2_status", uio_out, 8'h20);
    txn(2'd2, 1'b1, 8'h44, "wr_sum");
    check("wr_sum_status", uio_out, 8'hE0);
    txn(2'd2, 1'b0, 8'h00, "rd_sum2");
    check("rd_sum2_data", uo_out, 8'h10);

    // Start held high for 20 cycles must launch exactly once.
    @(negedge clk);
    ui_in  = 8'h11;
    uio_in = 8'b0000_1101;
    busy_cyc  = 0;
    rises     = 0;
    prev_busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (uio_out[4]) busy_cyc++;
      if (uio_out[4] && !prev_busy) rises++;
      prev_busy = uio_out[4];
    end
    check("hold_busy_cycles", busy_cyc, 4);
    check("hold_launches", rises, 1);
    check("hold_status", uio_out, 8'hA0);
    uio_in = 8'h00;
    txn(2'd1, 1'b0, 8'h00, "rd_hold");
    check("rd_hold_data", uo_out, 8'h11);

    // A fresh start edge while busy must be ignored.
    @(negedge clk);
    ui_in  = 8'h22;
    uio_in = 8'b0000_1100;
    @(negedge clk);
    uio_in = 8'h00;
    @(negedge clk);
    ui_in  = 8'h99;
    uio_in = 8'b0000_1001;
    @(negedge clk);
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    check("busy_edge_done", uio_out, 8'hA0);
    repeat (6) @(negedge clk);
    check("busy_edge_no_relaunch", uio_out, 8'hA0);
    check("busy_edge_uo_kept", uo_out, 8'h11);
    txn(2'd0, 1'b0, 8'h00, "rd_a3");
    check("rd_a3_data", uo_out, 8'h22);
    txn(2'd2, 1'b0, 8'h00, "rd_sum3");
    check("rd_sum3_data", uo_out, 8'h33);

    // Reset two cycles into a write to register 0.
    @(negedge clk);
    ui_in  = 8'h77;
    uio_in = 8'b0000_1100;
    @(negedge clk);
    uio_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_uio_out", uio_out, 8'h00);
    check("rst_mid_uo_out", uo_out, 8'h00);
    check("rst_mid_uio_oe", uio_oe, 8'hF0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    txn(2'd0, 1'b0, 8'h00, "rd_a_post_rst");
    check("rd_a_post_rst_data", uo_out, 8'h00);
    check("rd_a_post_rst_status", uio_out, 8'h20);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
